// File: rtl/sdram_req_arbiter_pkg.sv
// Shared definitions for the SDRAM read-engine arbiter: FSM encoding,
// default timing constants and the command codes presented to the engine.
package sdram_req_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_REF_WAIT = 2'd2
    } arb_state_t;

    // Command chosen by the arbiter when it is idle
    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_READ    = 2'd1,
        CMD_REFRESH = 2'd2
    } eng_cmd_t;

    localparam int DEF_ADDR_W       = 13;
    localparam int DEF_DATA_W       = 64;
    localparam int DEF_REF_INTERVAL = 780;   // 7.8 us at 100 MHz
    localparam int DEF_TIMEOUT      = 64;

    // Watchdog width: enough to hold TIMEOUT-1, never narrower than 7 bits
    function automatic int wd_width(input int timeout);
        int w;
        w = $clog2(timeout);
        if (w < 7) begin
            w = 7;
        end
        return w;
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_refresh_timer.sv
// Free-running refresh interval counter. Raises ref_pending when the
// interval elapses; ref_ack clears it. Pending saturates at one request.
module sdram_refresh_timer
    import sdram_req_arbiter_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_ack,
    output logic ref_pending
);

    localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             w_expire;

    assign w_expire    = (r_cnt == '0);
    assign ref_pending = r_pending;

    // Down-count every cycle; a fresh expiry wins over an acknowledge in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= RELOAD;
            r_pending <= 1'b0;
        end else begin
            if (w_expire) begin
                r_cnt     <= RELOAD;
                r_pending <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
                if (ref_ack) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM read engine.
// One transaction outstanding at a time; periodic refresh takes priority
// at IDLE; every engine operation is guarded by a watchdog.
module sdram_req_arbiter
    import sdram_req_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr,
    output logic              mem_go,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ref_go,
    input  logic              ref_done,
    output logic              busy,
    output logic              err_sticky
);

    localparam int WD_W = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    logic              r_last_gnt;
    logic              r_gnt_id;
    logic [WD_W-1:0]   r_wd;
    logic              r_mem_go;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_ref_go;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rerr;
    logic              r_err_sticky;

    logic              w_ref_pending;
    logic              w_ref_ack;
    logic              w_sel;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_wd_expired;
    eng_cmd_t          w_idle_cmd;

    sdram_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_refresh_timer (
        .clk        (clk),
        .rst        (rst),
        .ref_ack    (w_ref_ack),
        .ref_pending(w_ref_pending)
    );

    // Refresh is taken whenever IDLE sees it pending
    assign w_ref_ack = (r_state == ST_IDLE) && w_ref_pending;

    // Single requester wins outright; on contention the port not served last wins
    assign w_sel      = (req0 && req1) ? ~r_last_gnt : req1;
    assign w_sel_addr = w_sel ? addr1 : addr0;

    assign w_wd_expired = (r_wd == WD_LAST);

    // Decide what IDLE launches next: refresh ahead of reads
    always_comb begin
        w_idle_cmd = CMD_NONE;
        if (w_ref_pending) begin
            w_idle_cmd = CMD_REFRESH;
        end else if (req0 || req1) begin
            w_idle_cmd = CMD_READ;
        end
    end

    // Arbiter FSM with watchdog; all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_gnt   <= 1'b1;
            r_gnt_id     <= 1'b0;
            r_wd         <= '0;
            r_mem_go     <= 1'b0;
            r_mem_addr   <= '0;
            r_ref_go     <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata      <= '0;
            r_rerr       <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_mem_go  <= 1'b0;
            r_ref_go  <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rerr    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    case (w_idle_cmd)
                        CMD_REFRESH: begin
                            r_state  <= ST_REF_WAIT;
                            r_ref_go <= 1'b1;
                            r_wd     <= '0;
                        end
                        CMD_READ: begin
                            r_state    <= ST_RD_WAIT;
                            r_mem_go   <= 1'b1;
                            r_mem_addr <= w_sel_addr;
                            r_gnt_id   <= w_sel;
                            r_last_gnt <= w_sel;
                            r_wd       <= '0;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_RD_WAIT: begin
                    if (mem_valid) begin
                        r_rdata   <= mem_data;
                        r_rvalid0 <= ~r_gnt_id;
                        r_rvalid1 <= r_gnt_id;
                        r_state   <= ST_IDLE;
                    end else if (w_wd_expired) begin
                        r_rdata      <= '0;
                        r_rvalid0    <= ~r_gnt_id;
                        r_rvalid1    <= r_gnt_id;
                        r_rerr       <= 1'b1;
                        r_err_sticky <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_REF_WAIT: begin
                    if (ref_done) begin
                        r_state <= ST_IDLE;
                    end else if (w_wd_expired) begin
                        r_err_sticky <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign mem_go     = r_mem_go;
    assign mem_addr   = r_mem_addr;
    assign ref_go     = r_ref_go;
    assign rvalid0    = r_rvalid0;
    assign rvalid1    = r_rvalid1;
    assign rdata      = r_rdata;
    assign rerr       = r_rerr;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Bench for sdram_req_arbiter: behavioural engine, grant/response
// scoreboard, table of single-port reads and directed corner sequences.
module tb_sdram_req_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int REF_I  = 20;
    localparam int TMO    = 64;

    logic              clk;
    logic              rst;
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              rerr;
    logic              mem_go;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              ref_go;
    logic              ref_done;
    logic              busy;
    logic              err_sticky;

    sdram_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REF_INTERVAL(REF_I), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .rvalid0(rvalid0),
        .req1(req1), .addr1(addr1), .rvalid1(rvalid1),
        .rdata(rdata), .rerr(rerr),
        .mem_go(mem_go), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .ref_go(ref_go), .ref_done(ref_done),
        .busy(busy), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    typedef struct {
        logic              port;
        logic [ADDR_W-1:0] addr;
        int                lat;
        logic [DATA_W-1:0] data;
        logic              exp_err;
    } vec_t;

    int                checks = 0;
    int                errors = 0;
    logic              sb_en  = 1'b1;
    logic [ADDR_W-1:0] go_q[$];
    rsp_t              rsp_q[$];
    logic [DATA_W-1:0] mem_img[logic [ADDR_W-1:0]];
    int                eng_lat  = 3;
    logic              ref_mute = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic port, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic e);
        rsp_t r;
        r.port = port;
        r.data = e ? '0 : d;
        r.err  = e;
        go_q.push_back(a);
        rsp_q.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        go_q.delete();
        rsp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Engine model: read data after eng_lat cycles
    initial begin : engine_rd
        int                lat_l;
        logic [ADDR_W-1:0] a_l;
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_go) begin
                lat_l = eng_lat;
                a_l   = mem_addr;
                repeat (lat_l) @(negedge clk);
                mem_data  = mem_img.exists(a_l) ? mem_img[a_l] : (64'h0F0F_0000_0000_0000 | 64'(a_l));
                mem_valid = 1'b1;
                @(negedge clk);
                mem_valid = 1'b0;
            end
        end
    end

    // Engine model: refresh completes two cycles after ref_go unless muted
    initial begin : engine_ref
        ref_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ref_go && !ref_mute) begin
                repeat (2) @(negedge clk);
                ref_done = 1'b1;
                @(negedge clk);
                ref_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: grants and responses checked in expected order
    initial begin : monitor
        logic [ADDR_W-1:0] ea;
        rsp_t              er;
        forever begin
            @(negedge clk);
            if (sb_en && rst) begin
                if (mem_go) begin
                    if (go_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_mem_go: addr 0x%0h with no grant expected", mem_addr);
                    end else begin
                        ea = go_q.pop_front();
                        check("mem_addr", 64'(mem_addr), 64'(ea));
                    end
                end
                if (rvalid0 || rvalid1) begin
                    check("rvalid_onehot", 64'(rvalid0 & rvalid1), 64'h0);
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rvalid: rvalid0=%0b rvalid1=%0b, none expected", rvalid0, rvalid1);
                    end else begin
                        er = rsp_q.pop_front();
                        $display("rsp port=%0d rdata=0x%016h rerr=%0b", rvalid1, rdata, rerr);
                        check("rsp_port", 64'(rvalid1), 64'(er.port));
                        check("rsp_rdata", rdata, er.data);
                        check("rsp_rerr", 64'(rerr), 64'(er.err));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    vec_t tbl[6];

    initial begin : main
        int k, go_wait, rsp_wait, nrsp, first_go, second_go, nref, go_after_ref;
        logic outstanding, first_done;

        tbl[0] = '{1'b0, 13'h0123,  9, 64'hDEADBEEF_CAFEF00D, 1'b0};
        tbl[1] = '{1'b1, 13'h1ABC,  0, 64'h01234567_89ABCDEF, 1'b0};
        tbl[2] = '{1'b0, 13'h0000,  1, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        tbl[3] = '{1'b1, 13'h1FFF, 63, 64'h55555555_55555555, 1'b0};
        tbl[4] = '{1'b0, 13'h0456, 64, 64'hAAAAAAAA_AAAAAAAA, 1'b1};
        tbl[5] = '{1'b1, 13'h0789,  5, 64'h11223344_55667788, 1'b0};

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_mem_go", 64'(mem_go), 64'h0);
        check("reset_ref_go", 64'(ref_go), 64'h0);
        check("reset_rvalid", 64'({rvalid0, rvalid1}), 64'h0);
        check("reset_rerr", 64'(rerr), 64'h0);
        check("reset_err_sticky", 64'(err_sticky), 64'h0);
        check("reset_rdata", rdata, 64'h0);
        check("reset_mem_addr", 64'(mem_addr), 64'h0);

        // ---- table of single-port reads ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mem_img[tbl[i].addr] = tbl[i].data;
            eng_lat = tbl[i].lat;
            push_txn(tbl[i].port, tbl[i].addr, tbl[i].data, tbl[i].exp_err);
            if (tbl[i].port) begin req1 = 1'b1; addr1 = tbl[i].addr; end
            else begin req0 = 1'b1; addr0 = tbl[i].addr; end
            go_wait = 0;
            do begin @(negedge clk); go_wait++; end while (!mem_go && go_wait < 200);
            check("tbl_mem_go_seen", 64'(mem_go), 64'h1);
            if (i == 0) check("tbl_req_to_go", 64'(go_wait), 64'd1);
            check("tbl_busy", 64'(busy), 64'h1);
            rsp_wait = 0;
            do begin @(negedge clk); rsp_wait++; end while (!(rvalid0 || rvalid1) && rsp_wait < 200);
            req0 = 1'b0; req1 = 1'b0;
            check("tbl_go_to_rvalid", 64'(rsp_wait), tbl[i].exp_err ? 64'd64 : 64'(tbl[i].lat + 1));
            @(negedge clk);
            check("tbl_rvalid_pulse", 64'({rvalid0, rvalid1, rerr}), 64'h0);
            check("tbl_rdata_hold", rdata, tbl[i].exp_err ? 64'h0 : tbl[i].data);
            check("tbl_err_sticky", 64'(err_sticky), (tbl[i].exp_err || i == 5) ? 64'h1 : 64'h0);
            repeat (2) @(negedge clk);
        end

        // ---- contention: both held, grants alternate starting at port 0 ----
        do_reset();
        eng_lat = 3;
        mem_img[13'h0010] = 64'h1000_0000_0000_0010;
        mem_img[13'h0020] = 64'h2000_0000_0000_0020;
        for (int i = 0; i < 4; i++)
            push_txn(i[0], (i % 2 == 0) ? 13'h0010 : 13'h0020,
                     (i % 2 == 0) ? 64'h1000_0000_0000_0010 : 64'h2000_0000_0000_0020, 1'b0);
        addr0 = 13'h0010; addr1 = 13'h0020; req0 = 1'b1; req1 = 1'b1;
        nrsp = 0; k = 0;
        while (nrsp < 4 && k < 400) begin
            @(negedge clk); k++;
            if (rvalid0 || rvalid1) nrsp++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("contention_count", 64'(nrsp), 64'd4);
        repeat (5) @(negedge clk);
        check("contention_left", 64'(rsp_q.size() + go_q.size()), 64'h0);

        // ---- refresh priority over a held port-1 request ----
        do_reset();
        sb_en = 1'b0; eng_lat = 7;
        addr1 = 13'h0033; req1 = 1'b1;
        outstanding = 1'b0; first_done = 1'b0; nref = 0; go_after_ref = 0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            if (rvalid1) outstanding = 1'b0;
            if (ref_go) begin
                check("ref_no_preempt", 64'(outstanding), 64'h0);
                nref++;
            end
            if ((mem_go || ref_go) && cyc >= REF_I + 1 && !first_done) begin
                check("ref_before_read", 64'(ref_go), 64'h1);
                first_done = 1'b1;
            end
            if (mem_go) begin
                outstanding = 1'b1;
                if (nref > 0) go_after_ref++;
            end
        end
        req1 = 1'b0;
        check("ref_seen", 64'(nref != 0), 64'h1);
        check("read_after_ref", 64'(go_after_ref != 0), 64'h1);

        // ---- refresh overrun: ref_done never returns ----
        do_reset();
        sb_en = 1'b1; ref_mute = 1'b1;
        first_go = 0; second_go = 0; nref = 0;
        for (int cyc = 1; cyc <= 140; cyc++) begin
            @(negedge clk);
            if (ref_go) begin
                nref++;
                if (nref == 1) first_go = cyc;
                if (nref == 2) second_go = cyc;
            end
            if (cyc == 84) check("ovr_sticky_before", 64'(err_sticky), 64'h0);
            if (cyc == 85) begin
                check("ovr_sticky_set", 64'(err_sticky), 64'h1);
                check("ovr_idle", 64'(busy), 64'h0);
            end
        end
        $display("refresh overrun: ref_go at %0d and %0d, total %0d", first_go, second_go, nref);
        check("ovr_first_ref_go", 64'(first_go), 64'd21);
        check("ovr_second_ref_go", 64'(second_go), 64'd86);
        check("ovr_ref_go_count", 64'(nref), 64'd2);
        check("ovr_sticky_hold", 64'(err_sticky), 64'h1);
        ref_mute = 1'b0;

        // ---- async reset in the middle of a read ----
        do_reset();
        eng_lat = 9;
        go_q.push_back(13'h0123);
        addr0 = 13'h0123; req0 = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!mem_go && k < 50);
        check("ar_mem_go", 64'(mem_go), 64'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'h0);
        check("ar_mem_go_low", 64'(mem_go), 64'h0);
        check("ar_rvalid0", 64'(rvalid0), 64'h0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nrsp = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (rvalid0 || rvalid1) nrsp++;
        end
        check("ar_no_stale_rvalid", 64'(nrsp), 64'h0);
        mem_img[13'h00AA] = 64'h0A0A_0A0A_0A0A_0A0A;
        mem_img[13'h00BB] = 64'h0B0B_0B0B_0B0B_0B0B;
        push_txn(1'b0, 13'h00AA, 64'h0A0A_0A0A_0A0A_0A0A, 1'b0);
        push_txn(1'b1, 13'h00BB, 64'h0B0B_0B0B_0B0B_0B0B, 1'b0);
        eng_lat = 2;
        addr0 = 13'h00AA; addr1 = 13'h00BB; req0 = 1'b1; req1 = 1'b1;
        nrsp = 0; k = 0;
        while (nrsp < 2 && k < 300) begin
            @(negedge clk); k++;
            if (rvalid0) req0 = 1'b0;
            if (rvalid1) req1 = 1'b0;
            if (rvalid0 || rvalid1) nrsp++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("ar_post_reset_count", 64'(nrsp), 64'd2);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Shares the single 64-bit SDRAM read engine between two requesters: port 0 is the compression-side fetch and port 1 is the encryption-side fetch.
- The SDRAM read engine uses a go / address / valid interface.
- The block also schedules periodic auto-refresh through the engine's refresh handshake.
- It enforces one outstanding transaction, round-robin fairness between requesters, refresh priority, and a watchdog timeout on every engine operation.

Parameters:
ADDR_W, 13, width of the request address passed to the engine.
DATA_W, 64, width of the read data returned by the engine.
REF_INTERVAL, 780, clk cycles between refresh requests (7.8 us at 100 MHz).
TIMEOUT, 64, maximum clk cycles to wait for mem_valid or ref_done before aborting.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-low.
req0  in  1  port 0 read request; level, held until rvalid0.
addr0  in  ADDR_W  port 0 address; stable while req0 is high.
rvalid0  out  1  one-cycle pulse: rdata/rerr belong to port 0.
req1  in  1  port 1 read request; level, held until rvalid1.
addr1  in  ADDR_W  port 1 address; stable while req1 is high.
rvalid1  out  1  one-cycle pulse: rdata/rerr belong to port 1.
rdata  out  DATA_W  read data, shared by both ports, qualified by rvalid0/rvalid1.
rerr  out  1  high with rvalidN when the transaction timed out (rdata = 0).
mem_go  out  1  one-cycle start pulse to the engine.
mem_addr  out  ADDR_W  address to the engine; held from mem_go until the transaction ends.
mem_valid  in  1  engine pulse: mem_data is valid.
mem_data  in  DATA_W  engine read data.
ref_go  out  1  one-cycle refresh start pulse to the engine.
ref_done  in  1  engine pulse: refresh complete.
busy  out  1  high in any state other than IDLE.
err_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset (rst low, async): state=IDLE; last_gnt=1 (port 0 wins first); ref_cnt=REF_INTERVAL-1; ref_pending=0; all outputs 0.
- FSM states: IDLE, RD_WAIT, REF_WAIT.
- IDLE, priority order:
  - ref_pending=1 → REF_WAIT, ref_go<=1, ref_pending<=0.
  - else any req → RD_WAIT, mem_go<=1, mem_addr<=addr of the selected port, gnt_id<=selected port, last_gnt<=selected port.
  - Selection: if only one req is high, that port wins. If both are high, the port != last_gnt wins.
- mem_go and ref_go are registered and high for exactly the first cycle of RD_WAIT / REF_WAIT.
- Request latency: mem_go rises on the clock edge after the one where IDLE first samples reqN high (1 cycle min).
- RD_WAIT:
  - mem_valid=1 → rdata<=mem_data, rvalid[gnt_id]<=1, rerr<=0, go to IDLE.
  - Watchdog reaches TIMEOUT-1 without mem_valid → rdata<=0, rvalid[gnt_id]<=1, rerr<=1, err_sticky<=1, go to IDLE.
- REF_WAIT:
  - ref_done=1 → go to IDLE.
  - Timeout → err_sticky<=1, go to IDLE. No rvalid is issued.
- rvalidN and rerr are high for exactly one cycle. rdata holds its value until the next completion.
- Watchdog: cleared on entry to RD_WAIT/REF_WAIT, increments each cycle in those states, 7-bit minimum (wide enough for TIMEOUT).
- mem_valid/ref_done in the wrong state (IDLE, or the other wait state) are ignored.
- Back-to-back: a requester samples rvalidN, then drops req or presents a new addr on the next cycle. IDLE is always occupied for at least 1 cycle between transactions, so a req still high in that cycle is treated as a new request.
- Refresh timer:
  - ref_cnt decrements every cycle in all states; at 0 it reloads REF_INTERVAL-1 and sets ref_pending.
  - If the timer expires again while ref_pending is already 1, pending stays 1 (no queue, no error).
  - Refresh is serviced at the next IDLE, ahead of waiting requests; a read in progress is never pre-empted.
- Simultaneous events:
  - ref_cnt expiry in the same cycle as an IDLE grant → the read issues, and refresh follows at the next IDLE.
  - req arriving in the same cycle as a completion → not granted until the following IDLE cycle.
- Reset mid-transaction returns to IDLE immediately. No rvalid is issued; outstanding engine activity is discarded.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, RD_WAIT=1, REF_WAIT=2; 2-bit).
  - Default REF_INTERVAL and TIMEOUT constants.
  - Command-code constants for the engine.
- One sub-module, sdram_refresh_timer: down-counter plus ref_pending flag, with inputs ref_ack (clear pending) and outputs ref_pending.
- Arbitration, watchdog and FSM stay in the top.

Test Plan:
- Single port 0 read: req0=1, addr0=0x0123; engine returns mem_valid with 0xDEADBEEF_CAFEF00D 9 cycles after mem_go → mem_go 1 cycle after req0, mem_addr=0x0123, rvalid0 1-cycle with rdata=0xDEADBEEF_CAFEF00D, rerr=0, rvalid1 stays 0.
- Contention: req0 and req1 both held high continuously with addresses 0x0010 / 0x0020 → grants alternate 0,1,0,1 for 4 transactions; mem_addr sequence 0x0010, 0x0020, 0x0010, 0x0020.
- Refresh priority: REF_INTERVAL=20, req1 held high → after ref_cnt expiry, ref_go issues at the next IDLE before the next mem_go; no read is pre-empted; ref_done returns to IDLE and the read follows.
- Timeout: req0=1, engine never asserts mem_valid, TIMEOUT=64 → rvalid0 with rerr=1 and rdata=0 exactly 64 cycles after mem_go; err_sticky=1 and stays 1.
- Refresh overrun: REF_INTERVAL=20, hold ref_done low with TIMEOUT=64 → err_sticky=1; after returning to IDLE exactly one further ref_go is issued (pending saturates, no double refresh).
- Async reset mid-read: assert rst low 3 cycles after mem_go → busy=0, mem_go=0, rvalid0=0 immediately; after release, a mem_valid pulse produces no rvalid; the first grant goes to port 0.
